// File: rtl/bcd2bin32_if.sv
// Handshake and data bundle between a BCD source and the bcd2bin32_seq converter.
// The master drives start and the digits. The slave returns status and the result.
interface bcd2bin32_if;
  logic        start;
  logic [3:0]  dig0;
  logic [3:0]  dig1;
  logic [3:0]  dig2;
  logic [3:0]  dig3;
  logic [3:0]  dig4;
  logic [3:0]  dig5;
  logic [3:0]  dig6;
  logic [3:0]  dig7;
  logic        busy;
  logic        done;
  logic [31:0] value;
  logic        err;

  modport master (
    output start, dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7,
    input  busy, done, value, err
  );

  modport slave (
    input  start, dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7,
    output busy, done, value, err
  );
endinterface

// File: rtl/bcd2bin32_seq.sv
// Sequential packed-BCD to 32-bit binary converter using Horner's method (one digit per clock).
// It flags any used nibble above 9. The value is still computed from all nibbles and is not saturated.
module bcd2bin32_seq #(
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  bcd2bin32_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  // Left-justify the used digits so the most significant used digit sits in the top nibble.
  localparam int unsigned LOAD_SHIFT = 32 - 4 * NUM_DIGITS;
  localparam logic [3:0]  LAST_CNT   = 4'(NUM_DIGITS - 1);

  state_e      state_q,   state_d;
  logic [31:0] acc_q,     acc_d;
  logic [31:0] sreg_q,    sreg_d;
  logic [3:0]  cnt_q,     cnt_d;
  logic        err_acc_q, err_acc_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;
  logic [31:0] value_q,   value_d;
  logic        err_q,     err_d;

  logic [31:0] digs_s;
  logic [31:0] load_s;
  logic [3:0]  top_s;
  logic [31:0] acc_x10_s;

  assign digs_s    = {bus.dig7, bus.dig6, bus.dig5, bus.dig4,
                      bus.dig3, bus.dig2, bus.dig1, bus.dig0};
  assign load_s    = digs_s << LOAD_SHIFT;
  assign top_s     = sreg_q[31:28];
  assign acc_x10_s = (acc_q << 3) + (acc_q << 1);

  // Next-state, datapath and output logic for the IDLE/CONV sequencer.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    value_d   = value_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sreg_d    = load_s;
          acc_d     = 32'd0;
          cnt_d     = 4'd0;
          err_acc_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_CONV;
        end else begin
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_CONV: begin
        acc_d     = acc_x10_s + {28'd0, top_s};
        sreg_d    = {sreg_q[27:0], 4'd0};
        err_acc_d = err_acc_q | (top_s > 4'd9);
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          value_d = acc_d;
          err_d   = err_acc_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          busy_d  = 1'b1;
          state_d = ST_CONV;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= 32'd0;
      sreg_q    <= 32'd0;
      cnt_q     <= 4'd0;
      err_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      value_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      err_acc_q <= err_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      value_q   <= value_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.value = value_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_bcd2bin32_seq.sv
// Randomized self-checking bench for bcd2bin32_seq.
// An 8-digit and a 4-digit build share the stimulus, and each is checked against a positional-sum reference model.
module tb_bcd2bin32_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bcd2bin32_if if8();
  bcd2bin32_if if4();

  bcd2bin32_seq #(.NUM_DIGITS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  bcd2bin32_seq #(.NUM_DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_last8 = 32'd0;
  logic [31:0] exp_last4 = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic s);
    {if8.dig7, if8.dig6, if8.dig5, if8.dig4, if8.dig3, if8.dig2, if8.dig1, if8.dig0} = d;
    {if4.dig7, if4.dig6, if4.dig5, if4.dig4, if4.dig3, if4.dig2, if4.dig1, if4.dig0} = d;
    if8.start = s;
    if4.start = s;
  endtask

  // Reference: value = sum of digit_i * 10^i over the used digits, with no BCD legality assumed.
  function automatic logic [31:0] ref_value(input logic [31:0] d, input int n);
    longint unsigned v = 0;
    longint unsigned w = 1;
    for (int i = 0; i < n; i++) begin
      v += longint'(d[4*i +: 4]) * w;
      w *= 10;
    end
    return v[31:0];
  endfunction

  function automatic logic ref_err(input logic [31:0] d, input int n);
    logic e = 1'b0;
    for (int i = 0; i < n; i++) e |= (d[4*i +: 4] > 4'd9);
    return e;
  endfunction

  function automatic logic [31:0] rand_digits();
    logic [31:0] d;
    for (int i = 0; i < 8; i++)
      d[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    return d;
  endfunction

  task automatic check_idle_reset(input string tag);
    check_eq({tag, " busy8"}, 32'(if8.busy), 32'd0);
    check_eq({tag, " done8"}, 32'(if8.done), 32'd0);
    check_eq({tag, " value8"}, if8.value, 32'd0);
    check_eq({tag, " err8"}, 32'(if8.err), 32'd0);
    check_eq({tag, " busy4"}, 32'(if4.busy), 32'd0);
    check_eq({tag, " done4"}, 32'(if4.done), 32'd0);
    check_eq({tag, " value4"}, if4.value, 32'd0);
    check_eq({tag, " err4"}, 32'(if4.err), 32'd0);
  endtask

  // One start pulse, then watch 12 cycles. Index k means sampled just after edge Ek, where E0 samples start.
  task automatic run_conv(input string tag, input logic [31:0] d);
    int dk8 = -1, dk4 = -1, nd8 = 0, nd4 = 0, nb8 = 0, nb4 = 0;
    logic [31:0] v8 = 32'd0, v4 = 32'd0;
    logic e8 = 1'b0, e4 = 1'b0, bd8 = 1'b1, bd4 = 1'b1;
    drive(d, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        drive($urandom, 1'b0);
        check_eq({tag, " hold8"}, if8.value, exp_last8);
        check_eq({tag, " hold4"}, if4.value, exp_last4);
      end
      if (if8.busy) nb8++;
      if (if4.busy) nb4++;
      if (if8.done) begin nd8++; dk8 = k; v8 = if8.value; e8 = if8.err; bd8 = if8.busy; end
      if (if4.done) begin nd4++; dk4 = k; v4 = if4.value; e4 = if4.err; bd4 = if4.busy; end
    end
    exp_last8 = ref_value(d, 8);
    exp_last4 = ref_value(d, 4);
    check_eq({tag, " done_cyc8"}, 32'(dk8), 32'd8);
    check_eq({tag, " ndone8"}, 32'(nd8), 32'd1);
    check_eq({tag, " busy_cnt8"}, 32'(nb8), 32'd8);
    check_eq({tag, " busy_at_done8"}, 32'(bd8), 32'd0);
    check_eq({tag, " value8"}, v8, exp_last8);
    check_eq({tag, " err8"}, 32'(e8), 32'(ref_err(d, 8)));
    check_eq({tag, " done_cyc4"}, 32'(dk4), 32'd4);
    check_eq({tag, " ndone4"}, 32'(nd4), 32'd1);
    check_eq({tag, " busy_cnt4"}, 32'(nb4), 32'd4);
    check_eq({tag, " busy_at_done4"}, 32'(bd4), 32'd0);
    check_eq({tag, " value4"}, v4, exp_last4);
    check_eq({tag, " err4"}, 32'(e4), 32'(ref_err(d, 4)));
  endtask

  initial begin
    logic [31:0] directed [6];
    int dk8 [2], dk4 [2];
    logic [31:0] dv8 [2], dv4 [2];
    int n8, n4, nd;

    directed = '{32'h12345678, 32'h99999999, 32'h00000000, 32'h0000000A, 32'h00000042, 32'hFFFF9876};
    drive(32'd0, 1'b0);
    #3 rst_n = 1'b0;
    #10 check_idle_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Directed digit patterns, with known absolute results spot-checked on top of the model.
    for (int i = 0; i < 6; i++) begin
      run_conv($sformatf("dir%0d", i), directed[i]);
      if (i == 0) check_eq("dir 12345678 abs", exp_last8, 32'h00BC614E);
      if (i == 1) check_eq("dir 99999999 abs", exp_last8, 32'h05F5E0FF);
      if (i == 3) check_eq("dir 0A abs", exp_last8, 32'h0000000A);
      if (i == 5) check_eq("dir 9876 abs", exp_last4, 32'd9876);
    end

    // Keep start high. The digits change after E3. Each build restarts in its done cycle.
    n8 = 0; n4 = 0;
    dk8 = '{-1, -1}; dk4 = '{-1, -1}; dv8 = '{32'd0, 32'd0}; dv4 = '{32'd0, 32'd0};
    drive(32'h00000123, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 3) drive(32'h00000456, 1'b1);
      if (if8.done && n8 < 2) begin dk8[n8] = k; dv8[n8] = if8.value; n8++; end
      if (if4.done && n4 < 2) begin dk4[n4] = k; dv4[n4] = if4.value; n4++; end
    end
    drive(32'd0, 1'b0);
    check_eq("held 1st cyc8", 32'(dk8[0]), 32'd8);
    check_eq("held 1st val8", dv8[0], 32'd123);
    check_eq("held 2nd cyc8", 32'(dk8[1]), 32'd17);
    check_eq("held 2nd val8", dv8[1], 32'd456);
    check_eq("held 1st cyc4", 32'(dk4[0]), 32'd4);
    check_eq("held 1st val4", dv4[0], 32'd123);
    check_eq("held 2nd cyc4", 32'(dk4[1]), 32'd9);
    check_eq("held 2nd val4", dv4[1], 32'd456);
    repeat (20) @(negedge clk);
    exp_last8 = 32'd456;
    exp_last4 = 32'd456;

    // Reset during cycle 4 of a conversion must abort it with no done pulse.
    drive(32'h87654321, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) drive(32'h87654321, 1'b0);
    end
    rst_n = 1'b0;
    #1 check_idle_reset("midreset");
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (if8.done || if4.done) nd++;
    end
    check_eq("no done after abort", 32'(nd), 32'd0);
    exp_last8 = 32'd0;
    exp_last4 = 32'd0;
    run_conv("after_reset", 32'h87654321);

    for (int i = 0; i < 20; i++) run_conv($sformatf("rnd%0d", i), rand_digits());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd2bin32_seq.md
Name: bcd2bin32_seq

Overview:
Sequential BCD-to-binary converter; the inverse of the team's 8-digit binary-to-BCD display formatter. Accepts up to eight packed BCD digits, for example keypad or operand entry for the factorial calculator, and produces a 32-bit unsigned binary value. It uses one multiply-by-10-and-add step per clock (Horner's method) with a start/busy/done handshake. Flags any non-decimal nibble.

Parameters:
NUM_DIGITS, 8, number of BCD digits converted (legal 1..8). dig0..dig(NUM_DIGITS-1) are used; higher digit ports are ignored. Sets latency.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only in IDLE
dig0  input  4  BCD units digit
dig1  input  4  BCD tens digit
dig2  input  4  BCD hundreds digit
dig3  input  4  BCD thousands digit
dig4  input  4  BCD 10^4 digit
dig5  input  4  BCD 10^5 digit
dig6  input  4  BCD 10^6 digit
dig7  input  4  BCD 10^7 digit (most significant)
busy  output  1  conversion in progress
done  output  1  one-cycle pulse: value/err updated
value  output  32  binary result, held until next done
err  output  1  a used digit was >9 in the last conversion, held with value

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and sets busy=0, done=0, value=0, err=0. Internal accumulator, shift register and counter are cleared. Reset mid-conversion aborts the conversion with no done pulse.
- States: IDLE, CONV.
- IDLE, start=1 at edge E0:
  - Latch the used digits into the internal shift register, most significant used digit first.
  - Set acc=0, cnt=0, err_acc=0, busy=1.
  - Go to CONV. Digits are not resampled after E0.
- CONV, each edge E1..E(NUM_DIGITS):
  - acc <= acc*10 + d, where d is the current top digit zero-extended to 32 bits.
  - Shift the next digit up.
  - err_acc |= (d > 9).
  - cnt++.
- At edge E(NUM_DIGITS):
  - value <= final acc, err <= final err_acc, done <= 1, busy <= 0.
  - Go to IDLE.
- Latency: done is high in the cycle after edge E(NUM_DIGITS), i.e., NUM_DIGITS cycles after start is sampled. busy is high for exactly NUM_DIGITS cycles.
- done is a single-cycle pulse and is cleared on the next edge.
- start while busy=1 is ignored (not queued).
- start high in the done cycle (state is IDLE) is accepted. Back-to-back conversions therefore have a period of NUM_DIGITS+1 cycles.
- Arithmetic:
  - acc*10 is implemented as (acc<<3)+(acc<<1), unsigned, 32-bit.
  - Max legal result is 99,999,999, which fits in 27 bits.
  - Illegal nibbles (10..15) are still used arithmetically. The worst case, all 0xF, gives 166,666,665, so no overflow.
  - err reports the illegal-nibble condition; value is not saturated.
- value and err change only at the done edge or at reset.

Test Plan:
- Reset, then dig7..dig0 = 1,2,3,4,5,6,7,8 with start pulsed one cycle -> busy high 8 cycles; done pulses at cycle 8; value=0x00BC614E (12345678); err=0.
- All digits 9 -> value=0x05F5E0FF (99999999), err=0. Then all digits 0 -> value=0x00000000, err=0.
- dig0=0xA, others 0 -> value=10 (0x0000000A), err=1. A following valid conversion of 00000042 -> value=0x2A, err=0.
- start held high continuously with inputs 00000123 changing to 00000456 at cycle 3 -> first done gives value 123 (digits latched at E0). Restart on the done cycle; second done after 9 more cycles gives value 456.
- rst_n pulled low at cycle 4 of a conversion of 87654321 -> busy=0, done=0, value=0, err=0 immediately; no done pulse afterward. A new start after reset converts correctly.
- NUM_DIGITS=4 build, digits dig3..dig0=9,8,7,6, dig7..dig4=0xF -> value=9876, err=0, done 4 cycles after start.
